ddl_event_builder: RTL and testbench

- Parametrised successor to the SRU DDL front-end event builder, running in the siu_foCLK domain.
- On each ready event it sends CDH_WORDS header words, then the payload of every unmasked DTC channel buffer in ascending channel order, then an N_TRL-word RCU trailer, then the end-of-event control word toward the SIU.
- New compared with the previous generation: channel count, RAM read latency and trailer length are parameters; masked channels are skipped with zero dead cycles; each channel has a word limit with truncation reporting; the end-of-event word honours backpressure.

---
 rtl/ddl_pkg.sv | 41 ++++
 rtl/ddl_ch_pick.sv | 32 +++
 rtl/ddl_event_builder.sv | 234 +++++++++++++++++++++++
 tb/tb_ddl_event_builder.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddl_pkg.sv
// Shared definitions for the DDL event builder: FSM encoding, trailer
// markers, end-of-event control word and the RCU trailer word builder.
package ddl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CDH,
        ST_SEL,
        ST_WAIT,
        ST_SEND,
        ST_TRL,
        ST_EOE,
        ST_GAP
    } ddl_state_t;

    localparam logic [1:0]  TRL_MARK = 2'b10;
    localparam logic [1:0]  TRL_LAST = 2'b11;
    localparam logic [31:0] EOE_WORD = 32'h64;

    // Word k of an n_trl-word trailer; words between 1 and the last are user words.
    function automatic logic [31:0] trl_word(
        input logic [4:0]  k,
        input logic [4:0]  n_trl,
        input logic [18:0] pcnt,
        input logic        terr,
        input logic [6:0]  trunc,
        input logic [31:0] user,
        input logic [9:0]  ver,
        input logic [8:0]  addr
    );
        if (k == 5'd0)
            return {TRL_MARK, 4'd0, 7'h0, pcnt};
        else if (k == 5'd1)
            return {TRL_MARK, 4'd1, 18'h0, terr, trunc};
        else if (k == n_trl - 5'd1)
            return {TRL_LAST, 4'(n_trl - 5'd1), ver, addr, 7'(n_trl)};
        else
            return user;
    endfunction

endpackage

// File: rtl/ddl_ch_pick.sv
// Next-unmasked-channel priority encoder: lowest index >= start whose mask bit
// is clear.
module ddl_ch_pick
    import ddl_pkg::*;
#(
    parameter int N_CH  = 40,
    parameter int PTR_W = $clog2(N_CH + 1)
) (
    input  logic [N_CH-1:0]  mask,
    input  logic [PTR_W-1:0] start,
    output logic             valid,
    output logic [PTR_W-1:0] idx
);

    logic [N_CH-1:0] cand;

    for (genvar i = 0; i < N_CH; i++) begin : g_cand
        assign cand[i] = !mask[i] && (PTR_W'(i) >= start);
    end

    always_comb begin
        valid = 1'b0;
        idx   = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (cand[i]) begin
                valid = 1'b1;
                idx   = PTR_W'(i);
            end
        end
    end

endmodule

// File: rtl/ddl_event_builder.sv
// SRU DDL front-end event builder: CDH, unmasked channel payloads, RCU trailer
// and end-of-event word toward the SIU, all gated by tx_ready.
module ddl_event_builder
    import ddl_pkg::*;
#(
    parameter int          N_CH       = 40,
    parameter int          ADDR_W     = 10,
    parameter int          RD_LAT     = 1,
    parameter int          CDH_WORDS  = 10,
    parameter int          N_TRL      = 9,
    parameter int          MAX_WORDS  = 1023,
    parameter int          GAP_CYCLES = 20,
    parameter logic [9:0]  RCU_VER    = 10'h2,
    parameter logic [8:0]  RCU_ADDR   = 9'h0
) (
    input  logic                     siu_foCLK,
    input  logic                     siu_reset_n,
    input  logic                     event_rdy,
    input  logic                     trig_err,
    input  logic [N_CH-1:0]          ch_mask,
    input  logic [CDH_WORDS*32-1:0]  cdh_data,
    input  logic [(N_TRL-3)*32-1:0]  trl_user,
    output logic [N_CH-1:0]          ram_en,
    output logic [ADDR_W-1:0]        ram_addr,
    input  logic [N_CH*33-1:0]       ram_dout,
    output logic                     read_confirm,
    input  logic                     tx_ready,
    output logic [31:0]              fbd_o,
    output logic                     fbten_n_o,
    output logic                     fbctrl_n_o,
    output logic                     tx_start,
    output logic [31:0]              ecnt,
    output logic [6:0]               trunc_cnt
);

    localparam int PTR_W = $clog2(N_CH + 1);
    localparam int CNT_W = 16;

    ddl_state_t         state, nxt_state;
    logic               ev_sync;
    logic [CNT_W-1:0]   cnt, nxt_cnt;
    logic [PTR_W-1:0]   ptr, nxt_ptr;
    logic [PTR_W-1:0]   sel_idx, nxt_sel_idx;
    logic [N_CH-1:0]    mask_q, nxt_mask_q;
    logic [N_CH-1:0]    nxt_ram_en;
    logic [ADDR_W-1:0]  nxt_ram_addr;
    logic               nxt_read_confirm;
    logic               nxt_tx_start;
    logic [31:0]        nxt_ecnt;
    logic [6:0]         nxt_trunc_cnt;
    logic [18:0]        payload_cnt, nxt_payload_cnt;
    logic               terr_q, nxt_terr_q;

    logic               pick_vld;
    logic [PTR_W-1:0]   pick_idx;
    logic [31:0]        cdh_word;
    logic [32:0]        sel_dout;
    logic [CNT_W-1:0]   uidx;
    logic [31:0]        user_word;
    logic               ch_full;

    ddl_ch_pick #(
        .N_CH  (N_CH),
        .PTR_W (PTR_W)
    ) u_pick (
        .mask  (mask_q),
        .start (ptr),
        .valid (pick_vld),
        .idx   (pick_idx)
    );

    assign cdh_word  = 32'(cdh_data >> {cnt, 5'd0});
    assign sel_dout  = 33'(ram_dout >> (32'(sel_idx) * 32'd33));
    assign uidx      = (cnt >= CNT_W'(2)) ? cnt - CNT_W'(2) : '0;
    assign user_word = 32'(trl_user >> {uidx, 5'd0});
    // ram_addr doubles as the per-channel sent-word count
    assign ch_full   = (ram_addr == ADDR_W'(MAX_WORDS));

    always_comb begin
        nxt_state        = state;
        nxt_cnt          = cnt;
        nxt_ptr          = ptr;
        nxt_sel_idx      = sel_idx;
        nxt_mask_q       = mask_q;
        nxt_ram_en       = ram_en;
        nxt_ram_addr     = ram_addr;
        nxt_read_confirm = read_confirm;
        nxt_tx_start     = tx_start;
        nxt_ecnt         = ecnt;
        nxt_trunc_cnt    = trunc_cnt;
        nxt_payload_cnt  = payload_cnt;
        nxt_terr_q       = terr_q;
        fbd_o            = '0;
        fbten_n_o        = 1'b1;
        fbctrl_n_o       = 1'b1;

        case (state)
            ST_IDLE: begin
                if (ev_sync) begin
                    nxt_state     = ST_CDH;
                    nxt_cnt       = '0;
                    nxt_tx_start  = 1'b1;
                    nxt_trunc_cnt = '0;
                end
            end
            ST_CDH: begin
                if (tx_ready) begin
                    fbd_o     = cdh_word;
                    fbten_n_o = 1'b0;
                    if (cnt == CNT_W'(CDH_WORDS - 1)) begin
                        nxt_cnt    = '0;
                        nxt_terr_q = trig_err;
                        if (trig_err) begin
                            nxt_state = ST_TRL;
                        end else begin
                            nxt_mask_q       = ch_mask;
                            nxt_read_confirm = 1'b1;
                            nxt_ptr          = '0;
                            nxt_state        = ST_SEL;
                        end
                    end else begin
                        nxt_cnt = cnt + CNT_W'(1);
                    end
                end
            end
            ST_SEL: begin
                nxt_cnt = '0;
                if (pick_vld) begin
                    nxt_sel_idx  = pick_idx;
                    nxt_ram_en   = N_CH'(1) << pick_idx;
                    nxt_ram_addr = '0;
                    nxt_state    = ST_WAIT;
                end else begin
                    nxt_ram_en       = '0;
                    nxt_read_confirm = 1'b0;
                    nxt_state        = ST_TRL;
                end
            end
            ST_WAIT: begin
                if (cnt == CNT_W'(RD_LAT - 1)) begin
                    nxt_cnt   = '0;
                    nxt_state = ST_SEND;
                end else begin
                    nxt_cnt = cnt + CNT_W'(1);
                end
            end
            ST_SEND: begin
                // end_flag wins over the limit so an exactly-full channel is not truncated
                if (sel_dout[32] || ch_full) begin
                    if (!sel_dout[32] && trunc_cnt != 7'h7f)
                        nxt_trunc_cnt = trunc_cnt + 7'd1;
                    nxt_ptr   = sel_idx + PTR_W'(1);
                    nxt_state = ST_SEL;
                end else if (tx_ready) begin
                    fbd_o           = sel_dout[31:0];
                    fbten_n_o       = 1'b0;
                    nxt_payload_cnt = payload_cnt + 19'd1;
                    nxt_ram_addr    = ram_addr + ADDR_W'(1);
                    nxt_cnt         = '0;
                    nxt_state       = ST_WAIT;
                end
            end
            ST_TRL: begin
                if (tx_ready) begin
                    fbd_o     = trl_word(cnt[4:0], 5'(N_TRL), payload_cnt, terr_q,
                                         trunc_cnt, user_word, RCU_VER, RCU_ADDR);
                    fbten_n_o = 1'b0;
                    if (cnt == CNT_W'(N_TRL - 1)) begin
                        nxt_cnt   = '0;
                        nxt_state = ST_EOE;
                    end else begin
                        nxt_cnt = cnt + CNT_W'(1);
                    end
                end
            end
            ST_EOE: begin
                if (tx_ready) begin
                    fbd_o      = EOE_WORD;
                    fbten_n_o  = 1'b0;
                    fbctrl_n_o = 1'b0;
                    nxt_ecnt   = ecnt + 32'd1;
                    nxt_cnt    = '0;
                    nxt_state  = ST_GAP;
                end
            end
            ST_GAP: begin
                if (cnt == CNT_W'(GAP_CYCLES - 1)) begin
                    nxt_cnt         = '0;
                    nxt_tx_start    = 1'b0;
                    nxt_payload_cnt = '0;
                    nxt_state       = ST_IDLE;
                end else begin
                    nxt_cnt = cnt + CNT_W'(1);
                end
            end
            default: nxt_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge siu_foCLK or negedge siu_reset_n) begin
        if (!siu_reset_n) begin
            state        <= ST_IDLE;
            ev_sync      <= 1'b0;
            cnt          <= '0;
            ptr          <= '0;
            sel_idx      <= '0;
            mask_q       <= '0;
            ram_en       <= '0;
            ram_addr     <= '0;
            read_confirm <= 1'b0;
            tx_start     <= 1'b0;
            ecnt         <= '0;
            trunc_cnt    <= '0;
            payload_cnt  <= '0;
            terr_q       <= 1'b0;
        end else begin
            state        <= nxt_state;
            ev_sync      <= event_rdy;
            cnt          <= nxt_cnt;
            ptr          <= nxt_ptr;
            sel_idx      <= nxt_sel_idx;
            mask_q       <= nxt_mask_q;
            ram_en       <= nxt_ram_en;
            ram_addr     <= nxt_ram_addr;
            read_confirm <= nxt_read_confirm;
            tx_start     <= nxt_tx_start;
            ecnt         <= nxt_ecnt;
            trunc_cnt    <= nxt_trunc_cnt;
            payload_cnt  <= nxt_payload_cnt;
            terr_q       <= nxt_terr_q;
        end
    end

endmodule

// File: tb/tb_ddl_event_builder.sv
// Scenario bench for ddl_event_builder: random buffers and headers, expected
// word stream built from the event format rules.
module tb_ddl_event_builder;

    localparam int N_CH       = 4;
    localparam int ADDR_W     = 4;
    localparam int RD_LAT     = 2;
    localparam int CDH_WORDS  = 3;
    localparam int N_TRL      = 5;
    localparam int MAX_WORDS  = 4;
    localparam int GAP_CYCLES = 4;
    localparam int DEPTH      = 1 << ADDR_W;

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic                     event_rdy = 1'b0;
    logic                     trig_err = 1'b0;
    logic                     tx_ready = 1'b1;
    logic [N_CH-1:0]          ch_mask = '0;
    logic [CDH_WORDS*32-1:0]  cdh_data;
    logic [(N_TRL-3)*32-1:0]  trl_user;
    logic [N_CH-1:0]          ram_en;
    logic [ADDR_W-1:0]        ram_addr;
    logic [N_CH*33-1:0]       ram_dout;
    logic                     read_confirm, fbten_n_o, fbctrl_n_o, tx_start;
    logic [31:0]              fbd_o, ecnt;
    logic [6:0]               trunc_cnt;

    logic [31:0] cdh_w [CDH_WORDS];
    logic [31:0] usr_w [N_TRL-3];
    logic [31:0] mem [N_CH][DEPTH];
    int          len [N_CH];
    logic [ADDR_W-1:0] addr_d [RD_LAT];
    logic [N_CH-1:0]   cur_mask = '0;
    bit          rnd_rdy = 1'b0;

    logic [32:0] cap_q [$];
    logic [32:0] exp_q [$];
    int          exp_trunc;
    int          exp_ecnt = 0;
    int          bad_ten = 0, bad_en = 0, rc_cyc = 0, eoe_cnt = 0;
    int          en_cyc [N_CH];
    int          passed = 0, total = 0;
    int          cap_base;

    always #5 clk = ~clk;

    ddl_event_builder #(
        .N_CH(N_CH), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT), .CDH_WORDS(CDH_WORDS),
        .N_TRL(N_TRL), .MAX_WORDS(MAX_WORDS), .GAP_CYCLES(GAP_CYCLES),
        .RCU_VER(10'h2), .RCU_ADDR(9'h0)
    ) dut (
        .siu_foCLK(clk), .siu_reset_n(rst_n), .event_rdy(event_rdy),
        .trig_err(trig_err), .ch_mask(ch_mask), .cdh_data(cdh_data),
        .trl_user(trl_user), .ram_en(ram_en), .ram_addr(ram_addr),
        .ram_dout(ram_dout), .read_confirm(read_confirm), .tx_ready(tx_ready),
        .fbd_o(fbd_o), .fbten_n_o(fbten_n_o), .fbctrl_n_o(fbctrl_n_o),
        .tx_start(tx_start), .ecnt(ecnt), .trunc_cnt(trunc_cnt)
    );

    always_comb begin
        cdh_data = '0;
        for (int k = 0; k < CDH_WORDS; k++) cdh_data[k*32 +: 32] = cdh_w[k];
        trl_user = '0;
        for (int k = 0; k < N_TRL - 3; k++) trl_user[k*32 +: 32] = usr_w[k];
    end

    // Channel buffers: RD_LAT-cycle registered read, end_flag past the stored length
    always @(posedge clk) begin
        addr_d[0] <= ram_addr;
        for (int i = 1; i < RD_LAT; i++) addr_d[i] <= addr_d[i-1];
    end

    always_comb begin
        ram_dout = '0;
        for (int c = 0; c < N_CH; c++)
            if (int'(addr_d[RD_LAT-1]) >= len[c]) ram_dout[c*33 +: 33] = {1'b1, 32'h0};
            else ram_dout[c*33 +: 33] = {1'b0, mem[c][addr_d[RD_LAT-1]]};
    end

    initial forever begin
        @(posedge clk);
        #1;
        tx_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    always @(negedge clk) begin
        if (!fbten_n_o) cap_q.push_back({~fbctrl_n_o, fbd_o});
        if (!fbten_n_o && !fbctrl_n_o) eoe_cnt++;
        if (!fbten_n_o && !tx_ready) bad_ten++;
        if (fbten_n_o && (!fbctrl_n_o || fbd_o != 32'h0)) bad_ten++;
        if ((ram_en & cur_mask) != '0 || !$onehot0(ram_en)) bad_en++;
        if (read_confirm) rc_cyc++;
        for (int c = 0; c < N_CH; c++) if (ram_en[c]) en_cyc[c]++;
    end

    task automatic fill_rand();
        for (int k = 0; k < CDH_WORDS; k++) cdh_w[k] = $urandom;
        for (int k = 0; k < N_TRL - 3; k++) usr_w[k] = $urandom;
        for (int c = 0; c < N_CH; c++)
            for (int i = 0; i < DEPTH; i++) mem[c][i] = $urandom;
    endtask

    // Expected SIU stream for one event: header, capped payloads, trailer, EOE (bit 32 = control)
    function automatic void build_exp(input logic [N_CH-1:0] m, input bit terr);
        int pc = 0;
        int n;
        exp_q.delete();
        exp_trunc = 0;
        for (int k = 0; k < CDH_WORDS; k++) exp_q.push_back({1'b0, cdh_w[k]});
        if (!terr) begin
            for (int c = 0; c < N_CH; c++) begin
                if (m[c]) continue;
                n = (len[c] > MAX_WORDS) ? MAX_WORDS : len[c];
                if (len[c] > MAX_WORDS) exp_trunc++;
                for (int i = 0; i < n; i++) exp_q.push_back({1'b0, mem[c][i]});
                pc += n;
            end
        end
        exp_q.push_back({1'b0, 2'b10, 4'd0, 7'h0, 19'(pc)});
        exp_q.push_back({1'b0, 2'b10, 4'd1, 18'h0, terr, 7'(exp_trunc)});
        for (int k = 0; k < N_TRL - 3; k++) exp_q.push_back({1'b0, usr_w[k]});
        exp_q.push_back({1'b0, 2'b11, 4'(N_TRL - 1), 10'h2, 9'h0, 7'(N_TRL)});
        exp_q.push_back({1'b1, 32'h64});
    endfunction

    task automatic run_event(input logic [N_CH-1:0] m, input bit terr, output bit tmo);
        int eb;
        ch_mask  = m;
        cur_mask = m;
        trig_err = terr;
        cap_base = cap_q.size();
        eb       = eoe_cnt;
        build_exp(m, terr);
        @(posedge clk); #1 event_rdy = 1'b1;
        @(posedge clk); #1 event_rdy = 1'b0;
        tmo = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (eoe_cnt > eb) begin tmo = 1'b0; break; end
        end
        for (int c = 0; c < 200 && !tmo; c++) begin
            @(negedge clk);
            if (!tx_start) break;
        end
        if (!tmo && tx_start) tmo = 1'b1;
        if (!tmo) exp_ecnt++;
    endtask

    task automatic test_reset();
        logic [82:0] obs;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        obs = {fbten_n_o, fbctrl_n_o, tx_start, read_confirm, fbd_o, ram_en, ram_addr, ecnt, trunc_cnt};
        total++;
        if (obs !== {2'b11, 81'h0}) $display("FAIL reset_state got %h want %h", obs, {2'b11, 81'h0});
        else passed++;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        bit tmo;
        logic [32:0] got;
        int bt = bad_ten;
        fill_rand();
        len[0] = 3; len[1] = 0; len[2] = 2; len[3] = 1;
        run_event('0, 1'b0, tmo);
        total++; if (tmo) $display("FAIL basic_timeout got no EOE"); else passed++;
        total++;
        if (cap_q.size() - cap_base !== exp_q.size())
            $display("FAIL basic_len got %0d want %0d", cap_q.size() - cap_base, exp_q.size());
        else passed++;
        foreach (exp_q[i]) begin
            got = (cap_base + i < cap_q.size()) ? cap_q[cap_base + i] : 33'h0;
            total++;
            if (got !== exp_q[i]) $display("FAIL basic_word%0d got %h want %h", i, got, exp_q[i]);
            else passed++;
        end
        got = cap_q[cap_base + CDH_WORDS + 6];
        total++; if (got[18:0] !== 19'd6) $display("FAIL basic_w0_payload got %0d want 6", got[18:0]); else passed++;
        total++; if (ecnt !== 32'd1) $display("FAIL basic_ecnt got %0d want 1", ecnt); else passed++;
        total++; if (bad_ten !== bt) $display("FAIL basic_strobe got %0d bad cycles want 0", bad_ten - bt); else passed++;
    endtask

    task automatic test_mask();
        bit tmo;
        logic [32:0] got;
        int be = bad_en;
        int e0 = en_cyc[0], e1 = en_cyc[1], e2 = en_cyc[2], e3 = en_cyc[3];
        fill_rand();
        for (int c = 0; c < N_CH; c++) len[c] = $urandom_range(1, 4);
        run_event(4'b0101, 1'b0, tmo);
        total++; if (tmo) $display("FAIL mask_timeout got no EOE"); else passed++;
        total++;
        if (cap_q.size() - cap_base !== exp_q.size())
            $display("FAIL mask_len got %0d want %0d", cap_q.size() - cap_base, exp_q.size());
        else passed++;
        foreach (exp_q[i]) begin
            got = (cap_base + i < cap_q.size()) ? cap_q[cap_base + i] : 33'h0;
            total++;
            if (got !== exp_q[i]) $display("FAIL mask_word%0d got %h want %h", i, got, exp_q[i]);
            else passed++;
        end
        total++; if (bad_en !== be) $display("FAIL mask_ram_en got %0d bad cycles want 0", bad_en - be); else passed++;
        total++;
        if (en_cyc[0] != e0 || en_cyc[2] != e2 || en_cyc[1] == e1 || en_cyc[3] == e3)
            $display("FAIL mask_channels got cycles %0d/%0d/%0d/%0d want 0/>0/0/>0",
                     en_cyc[0] - e0, en_cyc[1] - e1, en_cyc[2] - e2, en_cyc[3] - e3);
        else passed++;
        total++; if (ecnt !== 32'(exp_ecnt)) $display("FAIL mask_ecnt got %0d want %0d", ecnt, exp_ecnt); else passed++;
    endtask

    task automatic test_trig_err();
        bit tmo;
        logic [32:0] got;
        int rc = rc_cyc;
        fill_rand();
        for (int c = 0; c < N_CH; c++) len[c] = $urandom_range(1, 6);
        run_event(4'($urandom), 1'b1, tmo);
        trig_err = 1'b0;
        total++; if (tmo) $display("FAIL terr_timeout got no EOE"); else passed++;
        total++;
        if (cap_q.size() - cap_base !== CDH_WORDS + N_TRL + 1)
            $display("FAIL terr_len got %0d want %0d", cap_q.size() - cap_base, CDH_WORDS + N_TRL + 1);
        else passed++;
        foreach (exp_q[i]) begin
            got = (cap_base + i < cap_q.size()) ? cap_q[cap_base + i] : 33'h0;
            total++;
            if (got !== exp_q[i]) $display("FAIL terr_word%0d got %h want %h", i, got, exp_q[i]);
            else passed++;
        end
        total++; if (rc_cyc !== rc) $display("FAIL terr_read_confirm got %0d high cycles want 0", rc_cyc - rc); else passed++;
        got = cap_q[cap_base + CDH_WORDS + 1];
        total++; if (got[7] !== 1'b1) $display("FAIL terr_w1_bit7 got %b want 1", got[7]); else passed++;
    endtask

    task automatic test_trunc();
        bit tmo;
        logic [32:0] got;
        fill_rand();
        len[0] = 10; len[1] = 2; len[2] = 4; len[3] = 1;
        run_event('0, 1'b0, tmo);
        total++; if (tmo) $display("FAIL trunc_timeout got no EOE"); else passed++;
        total++;
        if (cap_q.size() - cap_base !== exp_q.size())
            $display("FAIL trunc_len got %0d want %0d", cap_q.size() - cap_base, exp_q.size());
        else passed++;
        foreach (exp_q[i]) begin
            got = (cap_base + i < cap_q.size()) ? cap_q[cap_base + i] : 33'h0;
            total++;
            if (got !== exp_q[i]) $display("FAIL trunc_word%0d got %h want %h", i, got, exp_q[i]);
            else passed++;
        end
        total++; if (trunc_cnt !== 7'd1) $display("FAIL trunc_cnt got %0d want 1", trunc_cnt); else passed++;
        got = cap_q[cap_base + CDH_WORDS + 11 + 1];
        total++; if (got[6:0] !== 7'd1) $display("FAIL trunc_w1_field got %0d want 1", got[6:0]); else passed++;
    endtask

    task automatic test_backpressure();
        bit tmo;
        logic [32:0] got;
        int bt = bad_ten;
        rnd_rdy = 1'b1;
        for (int it = 0; it < 4; it++) begin
            fill_rand();
            for (int c = 0; c < N_CH; c++) len[c] = $urandom_range(0, 6);
            run_event(4'($urandom), 1'b0, tmo);
            total++; if (tmo) $display("FAIL bp%0d_timeout got no EOE", it); else passed++;
            total++;
            if (cap_q.size() - cap_base !== exp_q.size())
                $display("FAIL bp%0d_len got %0d want %0d", it, cap_q.size() - cap_base, exp_q.size());
            else passed++;
            foreach (exp_q[i]) begin
                got = (cap_base + i < cap_q.size()) ? cap_q[cap_base + i] : 33'h0;
                total++;
                if (got !== exp_q[i]) $display("FAIL bp%0d_word%0d got %h want %h", it, i, got, exp_q[i]);
                else passed++;
            end
            total++; if (trunc_cnt !== 7'(exp_trunc)) $display("FAIL bp%0d_trunc got %0d want %0d", it, trunc_cnt, exp_trunc); else passed++;
        end
        rnd_rdy = 1'b0;
        total++; if (bad_ten !== bt) $display("FAIL bp_strobe got %0d bad cycles want 0", bad_ten - bt); else passed++;
        total++; if (ecnt !== 32'(exp_ecnt)) $display("FAIL bp_ecnt got %0d want %0d", ecnt, exp_ecnt); else passed++;
    endtask

    task automatic test_reset_mid();
        bit tmo;
        bit hit = 1'b0;
        logic [32:0] got;
        logic [82:0] obs;
        int base;
        fill_rand();
        for (int c = 0; c < N_CH; c++) len[c] = 4;
        ch_mask = '0; cur_mask = '0; trig_err = 1'b0;
        base = cap_q.size();
        @(posedge clk); #1 event_rdy = 1'b1;
        @(posedge clk); #1 event_rdy = 1'b0;
        for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            if (read_confirm && cap_q.size() > base + CDH_WORDS + 2) begin hit = 1'b1; break; end
        end
        total++; if (!hit) $display("FAIL rstmid_reach got no payload"); else passed++;
        #1 rst_n = 1'b0;
        #1;
        exp_ecnt = 0;
        obs = {fbten_n_o, fbctrl_n_o, tx_start, read_confirm, fbd_o, ram_en, ram_addr, ecnt, trunc_cnt};
        total++;
        if (obs !== {2'b11, 81'h0}) $display("FAIL rstmid_state got %h want %h", obs, {2'b11, 81'h0});
        else passed++;
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        fill_rand();
        for (int c = 0; c < N_CH; c++) len[c] = $urandom_range(0, 5);
        run_event('0, 1'b0, tmo);
        total++; if (tmo) $display("FAIL rstmid_timeout got no EOE"); else passed++;
        total++;
        if (cap_q.size() - cap_base !== exp_q.size())
            $display("FAIL rstmid_len got %0d want %0d", cap_q.size() - cap_base, exp_q.size());
        else passed++;
        foreach (exp_q[i]) begin
            got = (cap_base + i < cap_q.size()) ? cap_q[cap_base + i] : 33'h0;
            total++;
            if (got !== exp_q[i]) $display("FAIL rstmid_word%0d got %h want %h", i, got, exp_q[i]);
            else passed++;
        end
        total++; if (ecnt !== 32'd1) $display("FAIL rstmid_ecnt got %0d want 1", ecnt); else passed++;
    endtask

    initial begin
        for (int c = 0; c < N_CH; c++) begin len[c] = 0; en_cyc[c] = 0; end
        fill_rand();
        test_reset();
        test_basic();
        test_mask();
        test_trig_err();
        test_trunc();
        test_backpressure();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog got no completion want finish");
        $fatal(1);
    end

endmodule
